// File: rtl/cmd_pkg.sv
// Shared command vocabulary for the command arbiter and the menu/cursor engine.
// Codes and source ids match what the downstream engine decodes.
package cmd_pkg;

  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_RIGHT = 2'd1;
  localparam logic [1:0] CMD_SEL   = 2'd2;
  localparam logic [1:0] CMD_RST   = 2'd3;

  localparam logic SRC_IR  = 1'b0;
  localparam logic SRC_KEY = 1'b1;

  typedef struct packed {
    logic       src;
    logic [1:0] code;
  } cmd_entry_t;

  // Lines are indexed by command code; RST beats SEL beats LEFT beats RIGHT.
  function automatic logic [1:0] cmd_prio(input logic [3:0] fall);
    if (fall[CMD_RST])
      return CMD_RST;
    else if (fall[CMD_SEL])
      return CMD_SEL;
    else if (fall[CMD_LEFT])
      return CMD_LEFT;
    else
      return CMD_RIGHT;
  endfunction

endpackage

// File: rtl/cmd_src_capture.sv
// One command source: falling-edge detect on four active-low lines, priority
// encode, hold-off window and a single-entry pending register.
module cmd_src_capture
  import cmd_pkg::*;
#(
  parameter int HOLDOFF = 1000,
  parameter int CW      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] line_n,
  input  logic       pend_clear,
  output logic       pend_valid,
  output logic [1:0] pend_code,
  output logic       drop
);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);

  logic [3:0]    prev;
  logic [3:0]    fall;
  logic [CW-1:0] hold_cnt;
  logic          capture;
  logic [1:0]    evt_code;

  assign fall     = prev & ~line_n;
  assign capture  = (|fall) && (hold_cnt == '0);
  assign evt_code = cmd_prio(fall);

  // A slot being emptied by the arbiter this cycle can take the new event.
  assign drop = capture && pend_valid && !pend_clear;

  always_ff @(posedge clk) begin
    prev <= line_n;
    if (!rst) begin
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_code  <= CMD_LEFT;
    end else begin
      if (capture)
        hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - CW'(1);

      if (capture && (!pend_valid || pend_clear)) begin
        pend_valid <= 1'b1;
        pend_code  <= evt_code;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Merges IR-remote and push-key commands into one ordered stream: two capture
// front ends, round-robin arbitration and a fall-through command FIFO.
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 1000,
  parameter int CW      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_left_n,
  input  logic       ir_right_n,
  input  logic       ir_sel_n,
  input  logic       ir_rst_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_sel_n,
  input  logic       key_rst_n,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       cmd_src,
  input  logic       cmd_ready,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0] pend_valid;
  logic [1:0] pend_clear;
  logic [1:0] drop;
  logic [1:0] pend_code [2];

  cmd_src_capture #(.HOLDOFF(HOLDOFF), .CW(CW)) u_cap_ir (
    .clk        (clk),
    .rst        (rst),
    .line_n     ({ir_rst_n, ir_sel_n, ir_right_n, ir_left_n}),
    .pend_clear (pend_clear[0]),
    .pend_valid (pend_valid[0]),
    .pend_code  (pend_code[0]),
    .drop       (drop[0])
  );

  cmd_src_capture #(.HOLDOFF(HOLDOFF), .CW(CW)) u_cap_key (
    .clk        (clk),
    .rst        (rst),
    .line_n     ({key_rst_n, key_sel_n, key_right_n, key_left_n}),
    .pend_clear (pend_clear[1]),
    .pend_valid (pend_valid[1]),
    .pend_code  (pend_code[1]),
    .drop       (drop[1])
  );

  cmd_entry_t      fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            rr;
  logic            win;
  cmd_entry_t      push_entry;
  cmd_entry_t      head;

  assign fifo_full = (count == (AW+1)'(DEPTH));
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr];

  // Contention goes to the pointed-at source; a lone requester always wins.
  always_comb begin
    win = SRC_IR;
    if (pend_valid == 2'b11)
      win = rr;
    else if (pend_valid[1])
      win = SRC_KEY;
  end

  always_comb begin
    push            = (|pend_valid) && (!fifo_full || pop);
    pend_clear      = 2'b00;
    pend_clear[win] = push;
    push_entry.src  = win;
    push_entry.code = pend_code[win];
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr       <= SRC_IR;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && (pend_valid == 2'b11))
        rr <= ~win;
      if (|drop)
        overflow <= 1'b1;
    end
  end

  // Empty FIFO presents a clean zero head rather than stale storage.
  assign cmd_code = cmd_valid ? head.code : CMD_LEFT;
  assign cmd_src  = cmd_valid ? head.src  : SRC_IR;
  assign busy     = (|pend_valid) || cmd_valid;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: a queue-based behavioural model predicts the
// command order; a negedge monitor checks every handshake and status output.
module tb_cmd_arbiter;
  import cmd_pkg::*;

  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 6;
  localparam int CW      = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ir_n  = 4'hF;
  logic [3:0] key_n = 4'hF;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_src;
  logic       overflow;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int hs_count   = 0;

  always #5 clk = ~clk;

  cmd_arbiter #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ir_left_n   (ir_n[0]),
    .ir_right_n  (ir_n[1]),
    .ir_sel_n    (ir_n[2]),
    .ir_rst_n    (ir_n[3]),
    .key_left_n  (key_n[0]),
    .key_right_n (key_n[1]),
    .key_sel_n   (key_n[2]),
    .key_rst_n   (key_n[3]),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_src     (cmd_src),
    .cmd_ready   (cmd_ready),
    .overflow    (overflow),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_prev [2];
  logic [3:0] m_cur  [2];
  logic [3:0] m_fall;
  int         m_hold [2];
  bit         m_pv   [2];
  int         m_pc   [2];
  int         m_fifo [$];
  int         sb     [$];
  int         m_rr;
  bit         m_ovf;
  int         m_w;
  int         m_code;
  bit         m_pop, m_push, m_both;
  int         prio_order [4] = '{3, 2, 0, 1};

  always @(posedge clk) begin
    m_cur[0] = ir_n;
    m_cur[1] = key_n;
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        m_prev[s] = m_cur[s];
        m_hold[s] = 0;
        m_pv[s]   = 1'b0;
        m_pc[s]   = 0;
      end
      m_fifo.delete();
      sb.delete();
      m_rr  = 0;
      m_ovf = 1'b0;
    end else begin
      m_pop  = (m_fifo.size() > 0) && cmd_ready;
      m_both = m_pv[0] && m_pv[1];
      m_w    = m_both ? m_rr : (m_pv[1] ? 1 : 0);
      m_push = (m_pv[0] || m_pv[1]) && ((m_fifo.size() < DEPTH) || m_pop);
      if (m_pop)
        void'(m_fifo.pop_front());
      if (m_push) begin
        m_fifo.push_back(m_w * 4 + m_pc[m_w]);
        sb.push_back(m_w * 4 + m_pc[m_w]);
        m_pv[m_w] = 1'b0;
        if (m_both)
          m_rr = 1 - m_w;
      end
      for (int s = 0; s < 2; s++) begin
        m_fall = m_prev[s] & ~m_cur[s];
        if (m_fall != 4'h0 && m_hold[s] == 0) begin
          m_hold[s] = HOLDOFF;
          m_code = -1;
          for (int k = 0; k < 4; k++)
            if (m_code < 0 && m_fall[prio_order[k]])
              m_code = prio_order[k];
          if (m_pv[s]) begin
            m_ovf = 1'b1;
          end else begin
            m_pv[s] = 1'b1;
            m_pc[s] = m_code;
          end
        end else if (m_hold[s] > 0) begin
          m_hold[s]--;
        end
        m_prev[s] = m_cur[s];
      end
    end
  end

  // ---------------- monitor ----------------
  int exp_ent;
  always @(negedge clk) begin
    check("valid", int'(cmd_valid), int'(m_fifo.size() > 0));
    check("busy", int'(busy), int'(m_pv[0] || m_pv[1] || (m_fifo.size() > 0)));
    check("overflow", int'(overflow), int'(m_ovf));
    if (rst && cmd_valid && cmd_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check("unexpected_cmd", int'({cmd_src, cmd_code}), -1);
      end else begin
        exp_ent = sb.pop_front();
        check("head", int'({cmd_src, cmd_code}), exp_ent);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int hs0;
  int mode;
  bit done;

  initial begin
    rst = 1'b0;
    tick(3);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_code", int'(cmd_code), 0);
    check("rst_src", int'(cmd_src), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick(2);

    // single IR left pulse
    cmd_ready = 1'b1;
    hs0 = hs_count;
    ir_n[CMD_LEFT] = 1'b0;
    tick(5);
    ir_n = 4'hF;
    tick(8);
    check("single_count", hs_count - hs0, 1);

    // simultaneous IR sel + key right, twice
    repeat (2) begin
      hs0 = hs_count;
      ir_n[CMD_SEL]    = 1'b0;
      key_n[CMD_RIGHT] = 1'b0;
      tick(2);
      ir_n  = 4'hF;
      key_n = 4'hF;
      tick(12);
      check("simul_count", hs_count - hs0, 2);
    end

    // overflow: six key pulses with consumer stalled
    cmd_ready = 1'b0;
    repeat (6) begin
      key_n[CMD_LEFT] = 1'b0;
      tick(2);
      key_n = 4'hF;
      tick(6);
    end
    check("ovf_set", int'(overflow), 1);
    hs0 = hs_count;
    cmd_ready = 1'b1;
    tick(12);
    check("ovf_drain_count", hs_count - hs0, 5);
    check("ovf_sticky", int'(overflow), 1);

    // same-source collision
    hs0 = hs_count;
    key_n[CMD_LEFT] = 1'b0;
    key_n[CMD_RST]  = 1'b0;
    tick(2);
    key_n = 4'hF;
    tick(10);
    check("collide_count", hs_count - hs0, 1);

    // hold-off: pulses at t0, t0+3, t0+10
    hs0 = hs_count;
    for (int t = 0; t < 20; t++) begin
      ir_n[CMD_RIGHT] = !(t == 0 || t == 3 || t == 10);
      tick();
    end
    ir_n = 4'hF;
    tick(4);
    check("holdoff_count", hs_count - hs0, 2);

    // reset with queued entries and ir_sel held low through release
    cmd_ready = 1'b0;
    ir_n[CMD_LEFT] = 1'b0;  tick(2); ir_n = 4'hF;  tick(8);
    ir_n[CMD_RIGHT] = 1'b0; tick(2); ir_n = 4'hF;  tick(8);
    key_n[CMD_SEL] = 1'b0;  tick(2); key_n = 4'hF; tick(8);
    check("pre_rst_busy", int'(busy), 1);
    ir_n[CMD_SEL] = 1'b0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    cmd_ready = 1'b1;
    hs0 = hs_count;
    tick(10);
    check("post_rst_valid", int'(cmd_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_count", hs_count - hs0, 0);
    ir_n[CMD_SEL] = 1'b1;
    tick(2);
    ir_n[CMD_SEL] = 1'b0;
    tick(2);
    ir_n = 4'hF;
    tick(6);
    check("refall_count", hs_count - hs0, 1);

    // randomized traffic
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0)
        mode = $urandom_range(0, 2);
      case (mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ($urandom_range(0, 3) == 0);
        default: cmd_ready = ($urandom_range(0, 1) == 0);
      endcase
      for (int l = 0; l < 4; l++) begin
        if (ir_n[l]) ir_n[l] = ($urandom_range(0, 11) != 0);
        else         ir_n[l] = ($urandom_range(0, 2) == 0);
        if (key_n[l]) key_n[l] = ($urandom_range(0, 11) != 0);
        else          key_n[l] = ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst = 1'b1;

    // drain
    ir_n = 4'hF;
    key_n = 4'hF;
    cmd_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      done = (sb.size() == 0) && !cmd_valid && !busy;
    end
    check("drain_done", int'(done), 1);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Merges two active-low command sources into one ordered command stream for the downstream menu/cursor engine.
  - Source 0: the IR remote decoder's cdleft/cdright/cdsel/cdrst pulses.
  - Source 1: the board push-keys, already debounced and synchronous to clk.
- Per-line falling-edge detection, per-source hold-off, round-robin arbitration between sources, small command FIFO, valid/ready output handshake.

Parameters:
- DEPTH, 4: FIFO entries, power of two, 2..16.
- HOLDOFF, 1000: clk cycles during which a source ignores new events after one is captured; 0 disables hold-off.
- CW, 10: hold-off counter width; must satisfy HOLDOFF < 2**CW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- ir_left_n, ir_right_n, ir_sel_n, ir_rst_n  in  1 each  source 0 command lines, active-low
- key_left_n, key_right_n, key_sel_n, key_rst_n  in  1 each  source 1 command lines, active-low
- cmd_valid  out  1  FIFO head valid
- cmd_code  out  2  head command: 0 LEFT, 1 RIGHT, 2 SEL, 3 RST
- cmd_src  out  1  head source: 0 IR, 1 key
- cmd_ready  in  1  consumer accepts head when cmd_valid & cmd_ready
- overflow  out  1  sticky; set when any event is dropped; cleared only by reset
- busy  out  1  high when any pending register or FIFO entry is occupied

Behaviour:
- Reset (rst=0 at clk edge):
  - FIFO emptied; pending registers cleared; hold-off counters set to 0; round-robin pointer set to 0.
  - cmd_valid=0, cmd_code=0, cmd_src=0, overflow=0, busy=0.
  - Each prev-sample register loads its current input value, so a line held low across reset release produces no event.
  - Reset mid-operation discards all queued commands.
- Edge detect: an event on a line occurs in a cycle where prev=1 and input=0. prev updates every cycle.
- Same-source collision: several lines of one source fall in the same cycle → one event, priority RST > SEL > LEFT > RIGHT; the others are discarded without setting overflow.
- Hold-off:
  - An event is captured only if that source's counter is 0. Capture loads the counter with HOLDOFF.
  - The counter decrements each cycle while nonzero.
  - Events during hold-off are ignored and do not set overflow.
- Pending register: one entry per source, written at the capture edge. If it is still full when a new event is captured, the new event is dropped and overflow is set.
- Arbiter: at most one FIFO push per cycle, and only when the FIFO is not full (after the same-cycle pop is accounted for).
  - One pending register full → it is pushed.
  - Both full → the source pointed to by the round-robin pointer wins; the pointer then flips to the other source.
  - The loser stays pending.
- FIFO:
  - Entry is {src, code}; first-word fall-through; cmd_valid = not empty.
  - Pop on cmd_valid & cmd_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Read/write pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- Latency: input first sampled low at edge N → pending set at N → FIFO written at N+1 (when not blocked) → cmd_valid=1 in the cycle after N+1.
- Outputs cmd_code/cmd_src are held stable while cmd_valid=1 and cmd_ready=0.

Decomposition:
- Shared package cmd_pkg:
  - Command code constants CMD_LEFT=0, CMD_RIGHT=1, CMD_SEL=2, CMD_RST=3.
  - Source constants SRC_IR=0, SRC_KEY=1.
  - Reused by the menu engine.
- Sub-module cmd_src_capture, instantiated twice: edge detect, priority encode, hold-off counter, pending register. It exposes pend_valid, pend_code, pend_clear and drop.
- The FIFO and arbiter stay in the top level.

Test Plan:
- Single IR pulse: ir_left_n low 5 cycles at edge 10, cmd_ready=1 → cmd_valid=1 for one cycle after edge 11 with code=0, src=0; overflow=0.
- Simultaneous events: ir_sel_n and key_right_n fall at the same edge, pointer=0, cmd_ready=1 → (code 2, src 0) then (code 1, src 1) on consecutive cycles. Repeat → key event is emitted first.
- Overflow: HOLDOFF=0, DEPTH=4, cmd_ready=0, six key pulses 3 cycles apart → FIFO holds 4 entries in order, pending holds the 5th, 6th dropped → overflow=1. Then cmd_ready=1 → 5 commands emitted in order.
- Same-source collision: key_left_n and key_rst_n fall together → exactly one command, code=3.
- Hold-off: HOLDOFF=20, ir_right_n pulses at edges 0, 10 and 25 → exactly two commands (from edges 0 and 25); overflow=0.
- Reset: rst=0 with 3 queued entries while ir_sel_n is held low; release rst with ir_sel_n still low → cmd_valid=0, busy=0, and no command appears until ir_sel_n rises and falls again.
